// File: rtl/hazard_ctrl.sv
// Decode/read-stage hazard sequencer: load scoreboard, RAW/WAW/full/CSR-drain stalls,
// and redirect flush timing.
module hazard_ctrl #(
  parameter int MAX_LOADS    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [4:0]                     id_rs1,
  input  logic [4:0]                     id_rs2,
  input  logic                           id_rs1_used,
  input  logic                           id_rs2_used,
  input  logic [4:0]                     id_rd,
  input  logic                           id_reg_we,
  input  logic                           id_mem_rr,
  input  logic                           id_csr_write,
  input  logic                           ex_redirect,
  input  logic                           mem_resp_valid,
  output logic                           stall,
  output logic                           bubble,
  output logic                           flush,
  output logic [4:0]                     resp_rd,
  output logic [$clog2(MAX_LOADS+1)-1:0] outstanding,
  output logic                           err_underflow
);
  localparam int AW = $clog2(MAX_LOADS);
  localparam int OW = $clog2(MAX_LOADS + 1);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pending_q, pending_d;
  logic [4:0]    fifo_q [MAX_LOADS];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] out_q;
  logic          err_q;
  logic          raw, waw, full, csr, issue, push, pop;
  logic          stall_c, bubble_c, flush_c;

  // Hazards look only at registered pending; a response this cycle clears them next cycle.
  assign raw  = id_valid & ((id_rs1_used & pending_q[id_rs1]) | (id_rs2_used & pending_q[id_rs2]));
  assign waw  = id_valid & id_reg_we & pending_q[id_rd];
  assign full = id_valid & id_mem_rr & (out_q == OW'(MAX_LOADS));
  assign csr  = id_valid & id_csr_write & (out_q != '0);
  assign pop  = mem_resp_valid & (out_q != '0);
  assign push = issue & id_mem_rr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    issue    = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = FLUSH;
          cnt_d    = CW'(FLUSH_CYCLES - 1);
        end else if (csr) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = DRAIN;
        end else if (raw | waw | full) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else begin
          issue = id_valid;
        end
      end
      FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        if (ex_redirect)        cnt_d   = CW'(FLUSH_CYCLES - 1);
        else if (cnt_q == '0)   state_d = RUN;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      DRAIN: begin
        if (ex_redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = FLUSH;
          cnt_d    = CW'(FLUSH_CYCLES - 1);
        end else if (out_q != '0) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else begin
          issue   = id_valid;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pop-clear first so a same-cycle reissue to the same rd stays pending.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[fifo_q[rd_ptr_q]] = 1'b0;
    if (push & id_reg_we & (id_rd != 5'd0)) pending_d[id_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_LOADS; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= id_reg_we ? id_rd : 5'd0;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push & ~pop)      out_q <= out_q + 1'b1;
      else if (~push & pop) out_q <= out_q - 1'b1;
      if (mem_resp_valid & (out_q == '0)) err_q <= 1'b1;
    end
  end

  assign stall         = stall_c  & ~rst;
  assign bubble        = bubble_c & ~rst;
  assign flush         = flush_c  & ~rst;
  assign resp_rd       = fifo_q[rd_ptr_q];
  assign outstanding   = out_q;
  assign err_underflow = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver queues expected outputs per cycle,
// monitor pops and compares at the falling edge.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_we, id_mem_rr, id_csr_write;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_redirect, mem_resp_valid;
  logic       stall, bubble, flush, err_underflow;
  logic [4:0] resp_rd;
  logic [2:0] outstanding;

  typedef struct {
    string      nm;
    logic       st, bu, fl;
    logic [2:0] out;
    logic [4:0] rrd;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  hazard_ctrl #(.MAX_LOADS(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_mem_rr(id_mem_rr), .id_csr_write(id_csr_write),
    .ex_redirect(ex_redirect), .mem_resp_valid(mem_resp_valid),
    .stall(stall), .bubble(bubble), .flush(flush), .resp_rd(resp_rd),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic setid(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic cs);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_we = we; id_mem_rr = ld; id_csr_write = cs;
  endtask

  task automatic idle();
    setid(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [4:0] rd);
    setid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk(input string nm, input logic st, input logic bu, input logic fl,
                     input logic [2:0] out, input logic [4:0] rrd, input logic err);
    exp_t e;
    e.nm = nm; e.st = st; e.bu = bu; e.fl = fl; e.out = out; e.rrd = rrd; e.err = err;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        nvec++;
        if (stall !== e.st || bubble !== e.bu || flush !== e.fl || outstanding !== e.out ||
            err_underflow !== e.err || (e.out != 0 && resp_rd !== e.rrd)) begin
          nerr++;
          $display("FAIL %s: got st=%b bu=%b fl=%b out=%0d rd=%0d err=%b, want st=%b bu=%b fl=%b out=%0d rd=%0d err=%b",
                   e.nm, stall, bubble, flush, outstanding, resp_rd, err_underflow,
                   e.st, e.bu, e.fl, e.out, e.rrd, e.err);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; mem_resp_valid = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    ex_redirect = 1'b1;
    chk("reset", 0, 0, 0, 0, 0, 0);
    ex_redirect = 1'b0; rst = 1'b0;

    // RAW on a pending load
    ld(5);                                                chk("raw_ld",        0, 0, 0, 0, 0, 0);
    setid(1, 5, 1, 1, 1, 6, 1, 0, 0);                     chk("raw_stall",     1, 1, 0, 1, 5, 0);
    mem_resp_valid = 1;                                   chk("raw_resp_edge", 1, 1, 0, 1, 5, 0);
    mem_resp_valid = 0;                                   chk("raw_issue",     0, 0, 0, 0, 0, 0);

    // Fill to MAX_LOADS, fifth load stalls until a response
    ld(1);                                                chk("full_ld1",   0, 0, 0, 0, 0, 0);
    ld(2);                                                chk("full_ld2",   0, 0, 0, 1, 1, 0);
    ld(3);                                                chk("full_ld3",   0, 0, 0, 2, 1, 0);
    ld(4);                                                chk("full_ld4",   0, 0, 0, 3, 1, 0);
    ld(7);                                                chk("full_stall", 1, 1, 0, 4, 1, 0);
    mem_resp_valid = 1;                                   chk("full_resp",  1, 1, 0, 4, 1, 0);
    mem_resp_valid = 0;                                   chk("full_issue", 0, 0, 0, 3, 2, 0);
    idle();                                               chk("full_out4",  0, 0, 0, 4, 2, 0);
    mem_resp_valid = 1;
    chk("fifo_rd2", 0, 0, 0, 4, 2, 0);
    chk("fifo_rd3", 0, 0, 0, 3, 3, 0);
    chk("fifo_rd4", 0, 0, 0, 2, 4, 0);
    chk("fifo_rd7", 0, 0, 0, 1, 7, 0);
    mem_resp_valid = 0;                                   chk("fifo_empty", 0, 0, 0, 0, 0, 0);

    // Push and pop in one cycle, then WAW on the surviving entry
    ld(8);                                                chk("pp_ld",     0, 0, 0, 0, 0, 0);
    ld(9); mem_resp_valid = 1;                            chk("pp_same",   0, 0, 0, 1, 8, 0);
    mem_resp_valid = 0; setid(1, 0, 0, 0, 0, 9, 1, 0, 0); chk("waw_stall", 1, 1, 0, 1, 9, 0);
    mem_resp_valid = 1;                                   chk("waw_resp",  1, 1, 0, 1, 9, 0);
    mem_resp_valid = 0;                                   chk("waw_issue", 0, 0, 0, 0, 0, 0);

    // CSR write drains two loads
    ld(10);                                               chk("csr_ld10",  0, 0, 0, 0, 0, 0);
    ld(11);                                               chk("csr_ld11",  0, 0, 0, 1, 10, 0);
    setid(1, 0, 0, 0, 0, 0, 0, 0, 1);                     chk("csr_stall", 1, 1, 0, 2, 10, 0);
    mem_resp_valid = 1;                                   chk("drain1",    1, 1, 0, 2, 10, 0);
                                                          chk("drain2",    1, 1, 0, 1, 11, 0);
    mem_resp_valid = 0;                                   chk("csr_issue", 0, 0, 0, 0, 0, 0);
    ld(12);                                               chk("post_csr_ld", 0, 0, 0, 0, 0, 0);
    setid(1, 1, 1, 0, 0, 13, 1, 0, 0);                    chk("run_again", 0, 0, 0, 1, 12, 0);
    idle(); mem_resp_valid = 1;                           chk("clr12",     0, 0, 0, 1, 12, 0);
    mem_resp_valid = 0;

    // Redirect during a RAW stall, reloaded once inside FLUSH
    ld(5);                                                chk("rd_ld",        0, 0, 0, 0, 0, 0);
    setid(1, 5, 1, 1, 1, 6, 1, 0, 0);                     chk("rd_raw",       1, 1, 0, 1, 5, 0);
    ex_redirect = 1;                                      chk("rd_redirect",  0, 1, 1, 1, 5, 0);
    ex_redirect = 0;                                      chk("flush1",       0, 1, 1, 1, 5, 0);
    ex_redirect = 1;                                      chk("flush2_reload",0, 1, 1, 1, 5, 0);
    ex_redirect = 0;                                      chk("flush3",       0, 1, 1, 1, 5, 0);
                                                          chk("flush4",       0, 1, 1, 1, 5, 0);
                                                          chk("rd_raw_again", 1, 1, 0, 1, 5, 0);
    mem_resp_valid = 1;                                   chk("rd_resp",      1, 1, 0, 1, 5, 0);
    mem_resp_valid = 0;                                   chk("rd_issue",     0, 0, 0, 0, 0, 0);

    // Underflow is sticky; x0 load counts; async reset mid-DRAIN
    idle(); mem_resp_valid = 1;                           chk("uf_resp",    0, 0, 0, 0, 0, 0);
    mem_resp_valid = 0;                                   chk("uf_sticky1", 0, 0, 0, 0, 0, 1);
                                                          chk("uf_sticky2", 0, 0, 0, 0, 0, 1);
    setid(1, 0, 0, 0, 0, 0, 1, 1, 0);                     chk("x0_ld",      0, 0, 0, 0, 0, 1);
    setid(1, 0, 0, 0, 0, 0, 0, 0, 1);                     chk("x0_csr",     1, 1, 0, 1, 0, 1);
                                                          chk("drain_hold", 1, 1, 0, 1, 0, 1);
    rst = 1;                                              chk("async_rst",  0, 0, 0, 0, 0, 0);
    rst = 0; idle();                                      chk("post_rst",   0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
